// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle RISC-V M-extension unit: funct3 op codes,
// FSM state encoding, decoder constants and operand-signedness helpers.
package muldiv_pkg;

   localparam logic [2:0] MD_OP_MUL    = 3'b000;
   localparam logic [2:0] MD_OP_MULH   = 3'b001;
   localparam logic [2:0] MD_OP_MULHSU = 3'b010;
   localparam logic [2:0] MD_OP_MULHU  = 3'b011;
   localparam logic [2:0] MD_OP_DIV    = 3'b100;
   localparam logic [2:0] MD_OP_DIVU   = 3'b101;
   localparam logic [2:0] MD_OP_REM    = 3'b110;
   localparam logic [2:0] MD_OP_REMU   = 3'b111;

   // The decoder routes an instruction here when opcode==OP and funct7==M.
   localparam logic [6:0] MD_OPCODE_OP = 7'b0110011;
   localparam logic [6:0] MD_FUNCT7_M  = 7'b0000001;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_t;

   function automatic logic op_rs1_signed(input logic [2:0] op);
      return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
   endfunction

   function automatic logic op_rs2_signed(input logic [2:0] op);
      return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle of muldiv_unit. Both sides use valid/ready: a transfer happens on
// a rising edge where valid and ready are both high; valid, once raised, holds its payload.
interface muldiv_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   import muldiv_pkg::*;

   logic             MD_flush;
   logic             MD_in_valid;
   logic             MD_in_ready;
   logic [2:0]       MD_op;
   logic [XLEN-1:0]  MD_rs1_data;
   logic [XLEN-1:0]  MD_rs2_data;
   logic [TAG_W-1:0] MD_tag_in;
   logic             MD_out_valid;
   logic             MD_out_ready;
   logic [XLEN-1:0]  MD_result;
   logic [TAG_W-1:0] MD_tag_out;
   logic             MD_busy;
   md_state_t        MD_dbg_state;

   modport master (
      output MD_flush, MD_in_valid, MD_op, MD_rs1_data, MD_rs2_data, MD_tag_in, MD_out_ready,
      input  MD_in_ready, MD_out_valid, MD_result, MD_tag_out, MD_busy, MD_dbg_state
   );

   modport slave (
      input  MD_flush, MD_in_valid, MD_op, MD_rs1_data, MD_rs2_data, MD_tag_in, MD_out_ready,
      output MD_in_ready, MD_out_valid, MD_result, MD_tag_out, MD_busy, MD_dbg_state
   );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply (hi:lo accumulator, multiplier in lo),
// restoring trial-subtract for divide (partial remainder in hi, quotient shifts into lo).
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] hi_nxt,
   output logic [XLEN-1:0] lo_nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] sh;
   logic [XLEN:0] diff;

   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      sh   = {hi, lo[XLEN-1]};
      diff = sh - {1'b0, b};
      if (is_div) begin
         // Remainder stays below the divisor, so a set top bit means the trial went negative.
         if (!diff[XLEN]) begin
            hi_nxt = diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = sh[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_nxt = sum[XLEN:1];
         lo_nxt = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit (mul/div/rem) with flush and rd tag pass-through.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle with a full multiplier.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic     SYS_clk,
   input  logic     SYS_reset_n,
   muldiv_if.slave  md
);

   localparam int CNT_W = $clog2(XLEN + 1);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  hi_q, lo_q, b_q;
   logic [2:0]       op_q;
   logic             neg_q;
   logic [TAG_W-1:0] tag_q;
   logic [XLEN-1:0]  result_q;
   logic [TAG_W-1:0] tag_out_q;
   logic             out_valid_q;

   logic            accept;
   logic            s1, s2;
   logic [XLEN-1:0] mag1, mag2;
   logic            in_is_div, in_is_rem;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] corner_res;
   logic [XLEN-1:0] hi_nxt, lo_nxt;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0] div_sel, div_s, fix_res;

   assign md.MD_in_ready  = (state == MD_IDLE) && !md.MD_flush;
   assign md.MD_busy      = (state != MD_IDLE);
   assign md.MD_out_valid = out_valid_q;
   assign md.MD_result    = result_q;
   assign md.MD_tag_out   = tag_out_q;
   assign md.MD_dbg_state = state;

   assign accept = md.MD_in_valid && md.MD_in_ready;

   always_comb begin
      s1        = op_rs1_signed(md.MD_op) & md.MD_rs1_data[XLEN-1];
      s2        = op_rs2_signed(md.MD_op) & md.MD_rs2_data[XLEN-1];
      mag1      = s1 ? -md.MD_rs1_data : md.MD_rs1_data;
      mag2      = s2 ? -md.MD_rs2_data : md.MD_rs2_data;
      in_is_div = op_is_div(md.MD_op);
      in_is_rem = op_is_rem(md.MD_op);
      div_zero  = in_is_div && (md.MD_rs2_data == '0);
      div_ovf   = (md.MD_op == MD_OP_DIV || md.MD_op == MD_OP_REM) &&
                  (md.MD_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (md.MD_rs2_data == '1);
      if (div_zero) corner_res = in_is_rem ? md.MD_rs1_data : '1;
      else          corner_res = in_is_rem ? '0 : md.MD_rs1_data;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_mag, fast_s;
   logic [XLEN-1:0]   fast_res;

   always_comb begin
      fast_mag = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
      fast_s   = (s1 ^ s2) ? -fast_mag : fast_mag;
      fast_res = (md.MD_op == MD_OP_MUL) ? fast_s[XLEN-1:0] : fast_s[2*XLEN-1:XLEN];
   end
`endif

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (op_q[2]),
      .hi     (hi_q),
      .lo     (lo_q),
      .b      (b_q),
      .hi_nxt (hi_nxt),
      .lo_nxt (lo_nxt)
   );

   // Sign correction happens on the magnitudes after the last iteration.
   always_comb begin
      prod    = {hi_q, lo_q};
      prod_s  = neg_q ? -prod : prod;
      div_sel = op_is_rem(op_q) ? hi_q : lo_q;
      div_s   = neg_q ? -div_sel : div_sel;
      if (op_q[2])               fix_res = div_s;
      else if (op_q == MD_OP_MUL) fix_res = prod_s[XLEN-1:0];
      else                        fix_res = prod_s[2*XLEN-1:XLEN];
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         state       <= MD_IDLE;
         cnt         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         b_q         <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         tag_q       <= '0;
         result_q    <= '0;
         tag_out_q   <= '0;
         out_valid_q <= 1'b0;
      end else if (md.MD_flush) begin
         state       <= MD_IDLE;
         cnt         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (accept) begin
                  op_q  <= md.MD_op;
                  tag_q <= md.MD_tag_in;
                  neg_q <= in_is_rem ? s1 : (s1 ^ s2);
                  hi_q  <= '0;
                  lo_q  <= in_is_div ? mag1 : mag2;
                  b_q   <= in_is_div ? mag2 : mag1;
                  cnt   <= CNT_W'(XLEN);
                  if (div_zero || div_ovf) begin
                     result_q    <= corner_res;
                     tag_out_q   <= md.MD_tag_in;
                     out_valid_q <= 1'b1;
                     state       <= MD_DONE;
`ifdef MULDIV_FAST_MUL_EN
                  end else if (!in_is_div) begin
                     result_q    <= fast_res;
                     tag_out_q   <= md.MD_tag_in;
                     out_valid_q <= 1'b1;
                     state       <= MD_DONE;
`endif
                  end else begin
                     state <= MD_CALC;
                  end
               end
            end
            MD_CALC: begin
               hi_q <= hi_nxt;
               lo_q <= lo_nxt;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= MD_FIX;
            end
            MD_FIX: begin
               result_q    <= fix_res;
               tag_out_q   <= tag_q;
               out_valid_q <= 1'b1;
               state       <= MD_DONE;
            end
            MD_DONE: begin
               if (md.MD_out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= MD_IDLE;
               end
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle RISC-V M-extension execution unit, parametrised in XLEN, with a valid/ready handshake on both sides. It replaces the single-cycle combinational mul/div/rem path in the datapath. The decoder issues an op when opcode=0110011 and funct7=0000001; the unit stalls the PC while busy.
It adds full M-spec corner cases (div-by-zero, signed overflow), a pipeline flush, and a result tag carrying rd.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
TAG_W, 5, width of the pass-through destination tag (rd).

Ports:
SYS_clk  in  1  clock; all state updates on the rising edge.
SYS_reset_n  in  1  reset, asynchronous assert, active-low.
MD_flush  in  1  synchronous abort of any in-flight op.
MD_in_valid  in  1  request valid.
MD_in_ready  out  1  unit can accept a request.
MD_op  in  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
MD_rs1_data  in  XLEN  operand A.
MD_rs2_data  in  XLEN  operand B.
MD_tag_in  in  TAG_W  rd tag, returned unchanged.
MD_out_valid  out  1  result valid.
MD_out_ready  in  1  consumer accepts the result.
MD_result  out  XLEN  result.
MD_tag_out  out  TAG_W  tag of the result.
MD_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (SYS_reset_n=0): state=IDLE and counter=0. MD_out_valid=0, MD_busy=0, MD_result=0, MD_tag_out=0; MD_in_ready=1 once reset is released.
- MD_in_ready = (state==IDLE) && !MD_flush. A request is accepted on an edge where MD_in_valid && MD_in_ready; this is edge N.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE->CALC on accept: latch operand magnitudes, result-sign flags, op and tag; counter=XLEN.
  - CALC: one radix-2 step per edge. Multiply is shift-add into a 2*XLEN accumulator; divide is restoring, one quotient bit per step. Counter decrements; on counter==1 the step is performed and the state goes to FIX.
  - FIX->DONE: apply sign correction (two's-complement negate where needed) and select the low or high half, or the quotient or remainder.
  - DONE: MD_out_valid=1, with MD_result and MD_tag_out held stable. DONE->IDLE on an edge with MD_out_ready=1.
- Normal latency: MD_out_valid first high in the cycle after edge N+XLEN+1 (XLEN+2 cycles; 34 for XLEN=32). The earliest next accept is the cycle after the result handshake.
- Signedness:
  - mul/mulh: both operands signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - mulhu/divu/remu: both unsigned.
  - Product is negated iff the operand signs differ. Quotient is negated iff the signs differ; remainder takes the sign of the dividend.
- Corner cases are detected at accept and go IDLE->DONE directly, with MD_out_valid in the cycle after edge N:
  - Divide by zero: div/divu give all-ones; rem/remu give rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1): div gives rs1; rem gives 0.
- MD_flush=1: next edge forces IDLE from any state; MD_out_valid=0 from that edge and the result is discarded. Flush wins over a simultaneous accept or result handshake.
- Reset asserted mid-operation: immediate return to the reset values; no partial result is ever presented.
- MD_out_ready low in DONE: hold indefinitely with no change to the outputs.
- Inputs are ignored outside IDLE; operands are not required to be held after accept.

Optional Feature:
MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops bypass CALC/FIX. At accept the full signed/unsigned 2*XLEN product is computed combinationally and registered, going IDLE->DONE with latency 1. Divides are unchanged.
- Undefined: all multiplies use the iterative path with XLEN+2 latency. No multiplier is inferred.

Decomposition:
- Shared package muldiv_pkg holds:
  - MD_OP_* localparams for the eight funct3 codes;
  - FSM state encodings (2 bits);
  - the M-extension funct7 constant 0000001, for the decoder.
- One natural sub-module: muldiv_step. It is a combinational single-iteration kernel (add/shift for mul, trial-subtract for div) parametrised by XLEN and instantiated once in CALC.

Test Plan:
- mul rs1=-3, rs2=7, XLEN=32 -> MD_result=0xFFFFFFEB, MD_out_valid 34 cycles after accept, tag echoed.
- High-half multiplies:
  - mulh 0x80000000*0x80000000 -> 0x40000000;
  - mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
  - mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Corner cases, each with latency 1:
  - div 7/0 -> 0xFFFFFFFF;
  - remu 7/0 -> 7;
  - div 0x80000000/0xFFFFFFFF -> 0x80000000;
  - rem of the same -> 0.
- Output backpressure: hold MD_out_ready=0 for 5 cycles in DONE -> result and tag stable, MD_in_ready=0; release -> IDLE next edge.
- Abort and reset:
  - MD_flush at CALC cycle 10 -> IDLE next edge, no MD_out_valid; a new op then completes correctly.
  - SYS_reset_n pulsed low mid-CALC -> outputs zero immediately.
  - With MULDIV_FAST_MUL_EN defined, mul completes with latency 1.
